// File: rtl/button_event_pkg.sv
// Shared types for the button event decoder: FSM state encoding and default timer width.
package button_event_pkg;

  localparam int DEFAULT_TIMER_WIDTH = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_SECOND,
    ST_SECOND_PRESSED
  } btn_state_t;

endpackage

// File: rtl/edge_detector.sv
// Rise/fall detector on the debounced level. The previous-sample register keeps tracking
// while disabled so that re-enabling never fabricates an edge.
module edge_detector (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_signal,
  output logic o_rise,
  output logic o_fall
);

  logic prev_reg;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= i_signal;
    end
  end

  assign o_rise = i_enable & i_signal & ~prev_reg;
  assign o_fall = i_enable & ~i_signal & prev_reg;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into press/release edges and short, long and
// double-click events; all events are registered single-cycle pulses, o_hold is a level.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_debounced_signal,
  input  logic [TIMER_WIDTH-1:0] i_long_press_ticks,
  input  logic [TIMER_WIDTH-1:0] i_double_click_ticks,
  output logic                   o_press_pulse,
  output logic                   o_release_pulse,
  output logic                   o_short_press,
  output logic                   o_long_press,
  output logic                   o_double_click,
  output logic                   o_hold
);

  logic                   rise;
  logic                   fall;
  btn_state_t             state_reg;
  btn_state_t             state_next;
  logic [TIMER_WIDTH-1:0] timer_reg;
  logic [TIMER_WIDTH-1:0] timer_next;
  logic                   short_next;
  logic                   long_next;
  logic                   double_next;
  logic                   hold_next;

  edge_detector u_edge_detector (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_signal (i_debounced_signal),
    .o_rise   (rise),
    .o_fall   (fall)
  );

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg + TIMER_WIDTH'(1);
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (rise) state_next = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall) begin
          state_next = ST_WAIT_SECOND;
        end else if (timer_reg >= i_long_press_ticks) begin
          state_next = ST_LONG_HELD;
          long_next  = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        timer_next = '0;
        if (fall) state_next = ST_IDLE;
      end
      ST_WAIT_SECOND: begin
        if (rise) begin
          state_next = ST_SECOND_PRESSED;
        end else if (timer_reg >= i_double_click_ticks) begin
          state_next = ST_IDLE;
          short_next = 1'b1;
        end
      end
      ST_SECOND_PRESSED: begin
        if (fall) begin
          state_next  = ST_IDLE;
          double_next = 1'b1;
        end else if (timer_reg >= i_long_press_ticks) begin
          state_next = ST_LONG_HELD;
          long_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase

    // Every transition is a state change, so this catches each state entry.
    if (state_next != state_reg) timer_next = '0;

    if (!i_enable) begin
      state_next  = ST_IDLE;
      timer_next  = '0;
      short_next  = 1'b0;
      long_next   = 1'b0;
      double_next = 1'b0;
    end

    hold_next = (state_next == ST_LONG_HELD);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg       <= ST_IDLE;
      timer_reg       <= '0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_short_press   <= 1'b0;
      o_long_press    <= 1'b0;
      o_double_click  <= 1'b0;
      o_hold          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      o_press_pulse   <= rise;
      o_release_pulse <= fall;
      o_short_press   <= short_next;
      o_long_press    <= long_next;
      o_double_click  <= double_next;
      o_hold          <= hold_next;
    end
  end

endmodule
